// File: rtl/sram_bank.sv
// rtl/sram_bank.sv - dual-port byte-enable SRAM bank with post-reset clear engine
// Port A read/write, port B read-only lookup; out-of-range accesses are flagged.
module sram_bank #(
  parameter int DATA_W         = 32,
  parameter int DEPTH          = 1056,
  parameter int ADDR_W         = 32,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                clk,
  input  logic                rst,
  output logic                ready,
  input  logic                a_ce,
  input  logic                a_we,
  input  logic [ADDR_W-1:0]   a_addr,
  input  logic [DATA_W/8-1:0] a_sel,
  input  logic [DATA_W-1:0]   a_wdata,
  output logic [DATA_W-1:0]   a_rdata,
  output logic                a_rvalid,
  output logic                a_err,
  input  logic                b_ce,
  input  logic [ADDR_W-1:0]   b_addr,
  output logic [DATA_W-1:0]   b_rdata,
  output logic                b_rvalid,
  output logic                b_err
);
  localparam int BYTES = DATA_W / 8;
  localparam int OFF   = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int WI_W  = ADDR_W - OFF;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [WI_W-1:0]  DEPTH_W = WI_W'(DEPTH);
  localparam logic [IDX_W-1:0] LAST    = IDX_W'(DEPTH - 1);

  typedef enum logic [1:0] {S_RESET, S_CLEAR, S_RUN} state_t;

  state_t            state, state_next;
  logic [IDX_W-1:0]  clr_cnt;
  logic [DATA_W-1:0] mem [DEPTH];

  logic [WI_W-1:0]   a_word, b_word;
  logic [IDX_W-1:0]  a_ix, b_ix;
  logic              a_ok, b_ok, a_wr, b_hit;
  logic [DATA_W-1:0] b_merged;
  logic              unused_addr_lsb;

  assign a_word = a_addr[ADDR_W-1:OFF];
  assign b_word = b_addr[ADDR_W-1:OFF];
  assign a_ix   = a_word[IDX_W-1:0];
  assign b_ix   = b_word[IDX_W-1:0];
  assign a_ok   = a_word < DEPTH_W;
  assign b_ok   = b_word < DEPTH_W;
  assign a_wr   = ready && a_ce && a_we && a_ok;
  assign b_hit  = a_wr && (a_ix == b_ix);
  assign unused_addr_lsb = ^{a_addr[OFF-1:0], b_addr[OFF-1:0]};

  always_comb begin
    state_next = state;
    ready      = 1'b0;
    case (state)
      S_RESET: state_next = (CLEAR_ON_RESET != 0) ? S_CLEAR : S_RUN;
      S_CLEAR: if (clr_cnt == LAST) state_next = S_RUN;
      S_RUN:   ready = 1'b1;
      default: state_next = S_RESET;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_RESET;
      clr_cnt <= '0;
    end else begin
      state   <= state_next;
      clr_cnt <= (state == S_CLEAR) ? clr_cnt + 1'b1 : '0;
    end
  end

  // Write-first view for a port B read landing on the word port A writes this cycle
  always_comb begin
    b_merged = mem[b_ix];
    if (b_hit) begin
      for (int i = 0; i < BYTES; i++)
        if (a_sel[i]) b_merged[8*i +: 8] = a_wdata[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && state == S_CLEAR) begin
      mem[clr_cnt] <= '0;
    end else if (!rst && a_wr) begin
      for (int i = 0; i < BYTES; i++)
        if (a_sel[i]) mem[a_ix][8*i +: 8] <= a_wdata[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_rdata  <= '0;
      a_rvalid <= 1'b0;
      a_err    <= 1'b0;
    end else if (!ready || !a_ce) begin
      a_rvalid <= 1'b0;
      a_err    <= 1'b0;
    end else if (!a_ok) begin
      a_rdata  <= '0;
      a_rvalid <= 1'b1;
      a_err    <= 1'b1;
    end else if (a_we) begin
      a_rdata  <= '0;
      a_rvalid <= 1'b0;
      a_err    <= 1'b0;
    end else begin
      a_rdata  <= mem[a_ix];
      a_rvalid <= 1'b1;
      a_err    <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      b_rdata  <= '0;
      b_rvalid <= 1'b0;
      b_err    <= 1'b0;
    end else if (!ready || !b_ce) begin
      b_rvalid <= 1'b0;
      b_err    <= 1'b0;
    end else if (!b_ok) begin
      b_rdata  <= '0;
      b_rvalid <= 1'b1;
      b_err    <= 1'b1;
    end else begin
      b_rdata  <= b_merged;
      b_rvalid <= 1'b1;
      b_err    <= 1'b0;
    end
  end
endmodule

// File: tb/tb_sram_bank.sv
// tb/tb_sram_bank.sv - directed self-checking bench for sram_bank
module tb_sram_bank;
  logic        clk = 1'b0;
  logic        rst;
  logic        ready;
  logic        a_ce, a_we;
  logic [31:0] a_addr, a_wdata, a_rdata;
  logic [3:0]  a_sel;
  logic        a_rvalid, a_err;
  logic        b_ce;
  logic [31:0] b_addr, b_rdata;
  logic        b_rvalid, b_err;

  int errors = 0;
  int checks = 0;
  int n;

  sram_bank dut (
    .clk(clk), .rst(rst), .ready(ready),
    .a_ce(a_ce), .a_we(a_we), .a_addr(a_addr), .a_sel(a_sel), .a_wdata(a_wdata),
    .a_rdata(a_rdata), .a_rvalid(a_rvalid), .a_err(a_err),
    .b_ce(b_ce), .b_addr(b_addr), .b_rdata(b_rdata), .b_rvalid(b_rvalid), .b_err(b_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    a_ce = 0; a_we = 0; a_addr = 0; a_sel = 0; a_wdata = 0;
    b_ce = 0; b_addr = 0;
  endtask

  task automatic a_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] sel);
    a_ce = 1; a_we = 1; a_addr = addr; a_wdata = data; a_sel = sel;
  endtask

  task automatic a_read(input logic [31:0] addr);
    a_ce = 1; a_we = 0; a_addr = addr; a_sel = 0; a_wdata = 0;
  endtask

  // Counts edges after the first rst-low edge until ready, injecting one
  // access pair mid-clear that must be ignored.
  task automatic wait_ready(output int cycles);
    cycles = 0;
    while (!ready && cycles < 2000) begin
      if (cycles == 100) begin
        a_write(32'h8, 32'hFFFF_FFFF, 4'hF);
        b_ce = 1; b_addr = 32'h8;
      end else if (cycles == 101) begin
        a_read(32'h8);
      end
      tick();
      cycles++;
      if (cycles == 102) begin
        check("busy_a_rvalid", {31'b0, a_rvalid}, 32'd0);
        check("busy_b_rvalid", {31'b0, b_rvalid}, 32'd0);
        idle();
      end
    end
  endtask

  initial begin
    idle();
    rst = 1;
    repeat (3) tick();
    check("rst_ready",    {31'b0, ready},    32'd0);
    check("rst_a_rdata",  a_rdata,           32'd0);
    check("rst_b_rdata",  b_rdata,           32'd0);
    check("rst_a_rvalid", {31'b0, a_rvalid}, 32'd0);
    check("rst_b_rvalid", {31'b0, b_rvalid}, 32'd0);
    check("rst_a_err",    {31'b0, a_err},    32'd0);
    check("rst_b_err",    {31'b0, b_err},    32'd0);

    rst = 0;
    tick();
    wait_ready(n);
    check("clear_cycles", n, 32'd1056);
    check("ready_up", {31'b0, ready}, 32'd1);

    b_ce = 1; b_addr = 32'h0;
    tick();
    check("b_rd0_data",  b_rdata,           32'h0);
    check("b_rd0_valid", {31'b0, b_rvalid}, 32'd1);
    b_addr = 32'h107C;
    a_read(32'h8);
    tick();
    check("b_rdlast_data",  b_rdata,           32'h0);
    check("b_rdlast_valid", {31'b0, b_rvalid}, 32'd1);
    check("b_rdlast_err",   {31'b0, b_err},    32'd0);
    check("busy_write_ignored", a_rdata, 32'h0);
    idle();

    a_write(32'h10, 32'hDEAD_BEEF, 4'b1111);
    tick();
    check("wr_a_rvalid", {31'b0, a_rvalid}, 32'd0);
    a_read(32'h10);
    tick();
    check("rd_full",       a_rdata,           32'hDEAD_BEEF);
    check("rd_full_valid", {31'b0, a_rvalid}, 32'd1);
    a_write(32'h10, 32'h1122_3344, 4'b0101);
    tick();
    a_read(32'h10);
    tick();
    check("rd_partial", a_rdata, 32'hDE22_BE44);
    idle();
    tick();
    check("hold_rdata",  a_rdata,           32'hDE22_BE44);
    check("hold_rvalid", {31'b0, a_rvalid}, 32'd0);

    a_write(32'h20, 32'h1234_5678, 4'hF);
    tick();
    a_write(32'h20, 32'hAAAA_BBBB, 4'b0011);
    b_ce = 1; b_addr = 32'h20;
    tick();
    check("collide_b", b_rdata, 32'h1234_BBBB);
    b_ce = 0;
    a_read(32'h20);
    tick();
    check("collide_after", a_rdata, 32'h1234_BBBB);

    a_write(32'h0, 32'h55AA_55AA, 4'hF);
    tick();
    a_write(32'h1080, 32'hFFFF_FFFF, 4'hF);
    tick();
    check("oor_a_err",    {31'b0, a_err},    32'd1);
    check("oor_a_rvalid", {31'b0, a_rvalid}, 32'd1);
    check("oor_a_rdata",  a_rdata,           32'h0);
    a_read(32'h0);
    tick();
    check("oor_a_err_drop", {31'b0, a_err}, 32'd0);
    check("oor_word0",      a_rdata,        32'h55AA_55AA);
    idle();
    b_ce = 1; b_addr = 32'h1080;
    tick();
    check("oor_b_rdata",  b_rdata,           32'h0);
    check("oor_b_rvalid", {31'b0, b_rvalid}, 32'd1);
    check("oor_b_err",    {31'b0, b_err},    32'd1);
    b_ce = 0;
    tick();
    check("oor_b_err_drop",    {31'b0, b_err},    32'd0);
    check("oor_b_rvalid_drop", {31'b0, b_rvalid}, 32'd0);

    a_write(32'h40, 32'hCAFE_F00D, 4'hF);
    tick();
    a_read(32'h40);
    tick();
    check("pre_clear_rd", a_rdata, 32'hCAFE_F00D);
    idle();
    rst = 1;
    tick();
    rst = 0;
    tick();
    repeat (300) tick();
    check("mid_clear_ready", {31'b0, ready}, 32'd0);
    rst = 1;
    tick();
    rst = 0;
    tick();
    wait_ready(n);
    check("reclear_cycles", n, 32'd1056);
    a_read(32'h40);
    tick();
    check("reclear_rd40", a_rdata, 32'h0);
    a_read(32'h10);
    tick();
    check("reclear_rd10", a_rdata, 32'h0);
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
